// File: rtl/wisc_pkg.sv
// Shared definitions for the pipeline control slice.
// REG_ID_W             : width of an architectural register id.
// DRAIN_CYCLES_DEFAULT : cycles needed to retire in-flight instructions after HLT.
// ctrl_state_e         : pipeline controller FSM encoding.
package wisc_pkg;

    localparam int unsigned REG_ID_W             = 4;
    localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StDrain   = 2'd2,
        StHalt    = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the datapath and the pipeline controller.
// Datapath -> controller: ID/EX load info, ID source ids, branch/HLT decode, memory handshake.
// Controller -> datapath: PC and pipeline register write enables, IF/ID flush, ID/EX bubble,
//                         halted flag and the saturating stall-cycle count.
// master: datapath side; slave: controller side.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import wisc_pkg::*;

    logic                idex_memread;
    logic [REG_ID_W-1:0] idex_rd;
    logic [REG_ID_W-1:0] ifid_rs;
    logic [REG_ID_W-1:0] ifid_rt;
    logic                ifid_uses_rt;
    logic                branch_taken_id;
    logic                hlt_id;
    logic                mem_req;
    logic                mem_ready;

    logic                pc_wen;
    logic                ifid_wen;
    logic                idex_wen;
    logic                exmem_wen;
    logic                memwb_wen;
    logic                ifid_flush;
    logic                idex_bubble;
    logic                halted;
    logic [CNT_W-1:0]    stall_cnt;

    modport master (
        output idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
        output branch_taken_id, hlt_id, mem_req, mem_ready,
        input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
        input  ifid_flush, idex_bubble, halted, stall_cnt
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
        input  branch_taken_id, hlt_id, mem_req, mem_ready,
        output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen,
        output ifid_flush, idex_bubble, halted, stall_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection.
// idex_memread_i : load held in ID/EX
// idex_rd_i      : its destination register
// ifid_rs_i/rt_i : sources of the instruction in ID
// ifid_uses_rt_i : ID instruction actually reads rt
// load_use_o     : ID instruction needs the load result one cycle too early
module hazard_detect
    import wisc_pkg::*;
(
    input  logic                idex_memread_i,
    input  logic [REG_ID_W-1:0] idex_rd_i,
    input  logic [REG_ID_W-1:0] ifid_rs_i,
    input  logic [REG_ID_W-1:0] ifid_rt_i,
    input  logic                ifid_uses_rt_i,
    output logic                load_use_o
);

    // R0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use_o = idex_memread_i && (idex_rd_i != '0) &&
                        ((idex_rd_i == ifid_rs_i) ||
                         (ifid_uses_rt_i && (idex_rd_i == ifid_rt_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: stalls for memory waits and load-use hazards, flushes on taken
// branches, drains and halts on HLT, and counts cycles in which the PC is frozen.
// clk : clock, rising edge
// rst : synchronous active-high reset
// bus : controller side of pipeline_ctrl_if (see interface header for signal list)
module pipeline_ctrl
    import wisc_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int unsigned CNT_W        = 16
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave bus
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    ctrl_state_e        state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic load_use;
    logic mem_wait;
    logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen;
    logic ifid_flush, idex_bubble;

    hazard_detect u_hazard_detect (
        .idex_memread_i (bus.idex_memread),
        .idex_rd_i      (bus.idex_rd),
        .ifid_rs_i      (bus.ifid_rs),
        .ifid_rt_i      (bus.ifid_rt),
        .ifid_uses_rt_i (bus.ifid_uses_rt),
        .load_use_o     (load_use)
    );

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        mem_wait    = 1'b0;
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        idex_wen    = 1'b1;
        exmem_wen   = 1'b1;
        memwb_wen   = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        unique case (state_q)
            StRun, StMemWait: begin
                // Once an access is outstanding only mem_ready can release it.
                mem_wait = (state_q == StMemWait) ? !bus.mem_ready
                                                  : (bus.mem_req && !bus.mem_ready);
                if (mem_wait) begin
                    state_d   = StMemWait;
                    pc_wen    = 1'b0;
                    ifid_wen  = 1'b0;
                    idex_wen  = 1'b0;
                    exmem_wen = 1'b0;
                    memwb_wen = 1'b0;
                end else begin
                    state_d = StRun;
                    if (load_use) begin
                        // Branch flush is suppressed; the branch re-resolves next cycle.
                        pc_wen      = 1'b0;
                        ifid_wen    = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (bus.hlt_id) begin
                        pc_wen  = 1'b0;
                        drain_d = DRAIN_LOAD;
                        state_d = (DRAIN_CYCLES == 0) ? StHalt : StDrain;
                    end else if (bus.branch_taken_id) begin
                        ifid_flush = 1'b1;
                    end
                end
            end
            StDrain: begin
                pc_wen = 1'b0;
                if (bus.mem_req && !bus.mem_ready) begin
                    // Freeze everything, including the drain count.
                    ifid_wen  = 1'b0;
                    idex_wen  = 1'b0;
                    exmem_wen = 1'b0;
                    memwb_wen = 1'b0;
                end else begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    drain_d     = (drain_q != '0) ? drain_q - DRAIN_W'(1) : '0;
                    if (drain_q <= DRAIN_W'(1)) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                pc_wen    = 1'b0;
                ifid_wen  = 1'b0;
                idex_wen  = 1'b0;
                exmem_wen = 1'b0;
                memwb_wen = 1'b0;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_wen && (state_q != StHalt) && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            drain_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    assign bus.pc_wen      = pc_wen;
    assign bus.ifid_wen    = ifid_wen;
    assign bus.idex_wen    = idex_wen;
    assign bus.exmem_wen   = exmem_wen;
    assign bus.memwb_wen   = memwb_wen;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.halted      = (state_q == StHalt);
    assign bus.stall_cnt   = stall_q;

endmodule
